// File: rtl/systolic_pkg.sv
// Shared defaults and FSM encoding for the systolic array operand feeders.
package systolic_pkg;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_STREAM = 3'b010,
    ST_FLUSH  = 3'b100
  } state_e;

  // Width of a counter that must hold LANES-1.
  function automatic int cnt_width(input int lanes);
    return (lanes > 1) ? ($clog2(lanes) + 1) : 1;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Show-ahead synchronous FIFO holding {vector, last} words; extra pointer MSB
// distinguishes full from empty.
module operand_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push_s, do_pop_s;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// Buffers activation row vectors and emits them diagonally skewed (lane i
// delayed i cycles) with per-lane valids, a busy flag and an end-of-frame done.
module operand_skew_feeder
  import systolic_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_last,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int FW = LANES * DATA_W + 1;
  localparam int CW = cnt_width(LANES);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LANES - 1);

  logic          fifo_full_s, fifo_empty_s, push_s, pop_s, rd_last_s;
  logic [FW-1:0] rd_word_s;
  state_e        state_q, state_d;
  logic [CW-1:0] flush_cnt_q, flush_cnt_d;
  logic          done_q, done_d;

  assign in_ready  = !fifo_full_s;
  assign push_s    = in_valid && !fifo_full_s;
  assign rd_last_s = rd_word_s[0];
  assign pop_s     = ((state_q == ST_IDLE) || (state_q == ST_STREAM)) && !fifo_empty_s;
  assign busy      = (state_q == ST_STREAM) || (state_q == ST_FLUSH);
  assign done      = done_q;

  operand_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({in_data, in_last}),
    .rd_data (rd_word_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // FLUSH holds off the next frame until the last row has crossed every lane.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (pop_s) begin
          if (rd_last_s) begin
            if (LANES == 1) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d     = ST_FLUSH;
              flush_cnt_d = CNT_LOAD;
            end
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q <= CNT_ONE) begin
          state_d     = ST_IDLE;
          flush_cnt_d = CNT_ZERO;
          done_d      = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        flush_cnt_d = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= CNT_ZERO;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  // Lane g is a g+1 deep shift chain; non-pop edges inject a zero bubble.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [g:0][DATA_W-1:0]   dat_q, dat_d;
    logic [g+1:0][DATA_W-1:0] dat_shf_s;
    logic [g:0]               vld_q, vld_d;
    logic [g+1:0]             vld_shf_s;
    logic [DATA_W-1:0]        lane_in_s;

    always_comb begin
      lane_in_s = pop_s ? rd_word_s[1 + g*DATA_W +: DATA_W] : {DATA_W{1'b0}};
      dat_shf_s = {dat_q, lane_in_s};
      vld_shf_s = {vld_q, pop_s};
      dat_d     = dat_shf_s[g:0];
      vld_d     = vld_shf_s[g:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dat_q <= {((g+1)*DATA_W){1'b0}};
        vld_q <= {(g+1){1'b0}};
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign out_data[g*DATA_W +: DATA_W] = dat_q[g];
    assign out_valid[g]                 = vld_q[g];
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Randomized scoreboard bench for operand_skew_feeder against a queue-based
// model of frame pops, skew timing, busy, in_ready and done.
module tb_operand_skew_feeder;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int NEXP   = 2048;

  logic                    clk, rst_n, in_valid, in_ready, in_last, busy, done;
  logic [LANES*DATA_W-1:0] in_data, out_data;
  logic [LANES-1:0]        out_valid;

  operand_skew_feeder #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (written only by the model process)
  logic [LANES*DATA_W:0] m_fifo [$];
  int                    edge_n, block_until;
  bit                    frame_open, exp_busy, exp_ready;
  int                    exp_cyc [LANES][NEXP];
  logic [DATA_W-1:0]     exp_dat [LANES][NEXP];
  int                    exp_wr [LANES];
  int                    done_exp [NEXP];
  int                    done_wr;

  // Monitor state (written only by the monitor process)
  int exp_rd [LANES];
  int done_rd, checks, errors;
  bit saw_full, fin_ack;

  // Stimulus state
  bit fin_req;
  int to_cnt;

  // Model: a vector leaves the queue whenever one is waiting and no frame is
  // still draining; its element i is due on lane i i edges later.
  initial begin
    int n_pre;
    logic [LANES*DATA_W:0] v;
    edge_n = 0; block_until = 0; frame_open = 1'b0;
    exp_busy = 1'b0; exp_ready = 1'b1; done_wr = 0;
    for (int i = 0; i < LANES; i++) exp_wr[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        frame_open  = 1'b0;
        block_until = edge_n;
        exp_busy    = 1'b0;
        exp_ready   = 1'b1;
      end else begin
        edge_n++;
        n_pre = m_fifo.size();
        if (n_pre > 0 && edge_n > block_until) begin
          v = m_fifo.pop_front();
          for (int i = 0; i < LANES; i++) begin
            exp_cyc[i][exp_wr[i]] = edge_n + i;
            exp_dat[i][exp_wr[i]] = v[1 + i*DATA_W +: DATA_W];
            exp_wr[i]++;
          end
          if (v[0]) begin
            frame_open  = 1'b0;
            block_until = edge_n + LANES - 1;
            done_exp[done_wr] = edge_n + LANES - 1;
            done_wr++;
          end else begin
            frame_open = 1'b1;
          end
        end
        if (in_valid && n_pre < DEPTH) m_fifo.push_back({in_data, in_last});
        exp_ready = (m_fifo.size() < DEPTH);
        exp_busy  = frame_open || (edge_n < block_until);
      end
    end
  end

  // Monitor: sampled on the falling edge, pops expectations as outputs appear.
  initial begin
    checks = 0; errors = 0; done_rd = 0; saw_full = 1'b0; fin_ack = 1'b0;
    for (int i = 0; i < LANES; i++) exp_rd[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checks++;
        if (out_valid !== '0 || out_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL reset_outputs: got valid=%b data=%h busy=%b done=%b, want all zero",
                   out_valid, out_data, busy, done);
        end
        for (int i = 0; i < LANES; i++) exp_rd[i] = exp_wr[i];
        done_rd = done_wr;
      end else begin
        checks++;
        if (in_ready !== exp_ready) begin
          errors++;
          $display("FAIL in_ready edge=%0d: got %b want %b", edge_n, in_ready, exp_ready);
        end
        if (!in_ready) saw_full = 1'b1;
        checks++;
        if (busy !== exp_busy) begin
          errors++;
          $display("FAIL busy edge=%0d: got %b want %b", edge_n, busy, exp_busy);
        end
        for (int i = 0; i < LANES; i++) begin
          checks++;
          if (out_valid[i] === 1'b1) begin
            if (exp_rd[i] >= exp_wr[i]) begin
              errors++;
              $display("FAIL lane%0d_spurious edge=%0d: got valid data=%h, want no valid",
                       i, edge_n, out_data[i*DATA_W +: DATA_W]);
            end else begin
              if (exp_cyc[i][exp_rd[i]] != edge_n ||
                  out_data[i*DATA_W +: DATA_W] !== exp_dat[i][exp_rd[i]]) begin
                errors++;
                $display("FAIL lane%0d_data edge=%0d: got data=%h, want data=%h at edge %0d",
                         i, edge_n, out_data[i*DATA_W +: DATA_W],
                         exp_dat[i][exp_rd[i]], exp_cyc[i][exp_rd[i]]);
              end
              exp_rd[i]++;
            end
          end else begin
            if (out_data[i*DATA_W +: DATA_W] !== {DATA_W{1'b0}}) begin
              errors++;
              $display("FAIL lane%0d_bubble edge=%0d: got data=%h, want 00",
                       i, edge_n, out_data[i*DATA_W +: DATA_W]);
            end else if (exp_rd[i] < exp_wr[i] && exp_cyc[i][exp_rd[i]] <= edge_n) begin
              errors++;
              $display("FAIL lane%0d_missing edge=%0d: got no valid, want data=%h",
                       i, edge_n, exp_dat[i][exp_rd[i]]);
              exp_rd[i]++;
            end
          end
        end
        checks++;
        if (done === 1'b1) begin
          if (done_rd >= done_wr || done_exp[done_rd] != edge_n) begin
            errors++;
            $display("FAIL done_spurious edge=%0d: got done=1, want done=0", edge_n);
          end
          if (done_rd < done_wr) done_rd++;
        end else if (done_rd < done_wr && done_exp[done_rd] <= edge_n) begin
          errors++;
          $display("FAIL done_missing edge=%0d: got done=0, want done=1 at edge %0d",
                   edge_n, done_exp[done_rd]);
          done_rd++;
        end
        if (fin_req && !fin_ack) begin
          for (int i = 0; i < LANES; i++) begin
            checks++;
            if (exp_rd[i] != exp_wr[i]) begin
              errors++;
              $display("FAIL lane%0d_drain: got %0d outputs, want %0d", i, exp_rd[i], exp_wr[i]);
            end
          end
          checks++;
          if (done_rd != done_wr) begin
            errors++;
            $display("FAIL done_count: got %0d, want %0d", done_rd, done_wr);
          end
          checks++;
          if (to_cnt != 0) begin
            errors++;
            $display("FAIL send_timeouts: got %0d, want 0", to_cnt);
          end
          checks++;
          if (!saw_full) begin
            errors++;
            $display("FAIL backpressure: got in_ready never low, want at least one full cycle");
          end
          fin_ack = 1'b1;
        end
      end
    end
  end

  // Called at a falling edge; holds the vector until accepted.
  task automatic send(input logic [LANES*DATA_W-1:0] d, input logic l);
    int  n;
    logic rdy;
    in_valid = 1'b1; in_data = d; in_last = l; n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!rdy && n < 200);
    if (!rdy) to_cnt++;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int len;
    fin_req = 1'b0; to_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    send(32'h04030201, 1'b1);
    idle(8);

    send($urandom, 1'b0); send($urandom, 1'b0); send($urandom, 1'b1);
    idle(8);

    send($urandom, 1'b0); idle(1); send($urandom, 1'b1);
    idle(8);

    // FLUSH window lets the FIFO fill while the 10-row frame keeps pushing
    send($urandom, 1'b1);
    for (int k = 0; k < 10; k++) send($urandom, k == 9);
    idle(20);

    send($urandom, 1'b0); send($urandom, 1'b1);
    send($urandom, 1'b0); send($urandom, 1'b0); send($urandom, 1'b1);
    idle(15);

    send($urandom, 1'b1);
    for (int k = 0; k < 5; k++) send($urandom, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    send(32'h14131211, 1'b1);
    idle(8);

    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send($urandom, k == len - 1);
        idle($urandom_range(0, 2));
      end
      idle($urandom_range(0, 3));
    end
    idle(20);

    fin_req = 1'b1;
    for (int k = 0; k < 20 && !fin_ack; k++) @(negedge clk);
    if (!fin_ack) $display("FAIL final_handshake: got no end-of-run checks, want them done");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_skew_feeder.md
Name: operand_skew_feeder

Overview:
- Upstream operand stage of the systolic MAC array: buffers row vectors of activations and emits them diagonally skewed, so lane i is delayed i cycles relative to lane 0.
- Per-lane out_valid drives the array's per-column valid inputs directly, matching the one-hot staggered pulses the loading controller produces.
- Frames are delimited by in_last.
- A done pulse fires once the last skewed element has left the array edge.

Parameters:
LANES, 4, number of array columns / vector elements
DATA_W, 8, bits per element
DEPTH, 4, input FIFO depth in vectors (power of 2, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream vector valid
in_ready  output  1  FIFO can accept (count < DEPTH)
in_data  input  LANES*DATA_W  vector; element i at [i*DATA_W +: DATA_W]
in_last  input  1  vector is last row of frame
out_data  output  LANES*DATA_W  skewed lane data to array column inputs
out_valid  output  LANES  per-lane valid to array
busy  output  1  high in STREAM or FLUSH
done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n low): FIFO empty, all skew registers cleared, state IDLE. out_data=0, out_valid=0, busy=0, done=0, flush counter 0. Takes effect immediately, including mid-frame. Abandoned data is lost and no done is issued.
- Push: on an edge with in_valid && in_ready, {in_data, in_last} is written. in_ready is combinational !full; there is no write-through when full.
- Pop: on an edge where state is IDLE or STREAM and the FIFO was non-empty before the edge. Pop and push on the same edge are both legal. A push into an empty FIFO is not visible to pop until the next edge.
- Skew pipeline: lane i is a chain of i+1 registers. A pop at edge p loads lane 0 with element 0 and valid=1 at edge p. Lane i element appears at out after edge p+i.
- Bubble: on any STREAM edge without a pop, lane-0 stage loads valid=0 and data=0. The bubble propagates skewed like data; no lane ever reuses stale data.
- Latency: push at edge k into an empty IDLE FIFO gives out_valid[0] high after edge k+1 and out_valid[LANES-1] high after edge k+LANES.
- FSM, one-hot encoded:
  - IDLE: busy=0. A pop moves to STREAM, or to FLUSH if the popped vector has last=1.
  - STREAM: busy=1. Pops each edge the FIFO is non-empty. A pop with last=1 moves to FLUSH and loads flush_cnt=LANES-1.
  - FLUSH: busy=1, no pops even if the FIFO is non-empty; the next frame waits. flush_cnt decrements each edge. At flush_cnt==1 the next edge goes to IDLE and registers done=1 for exactly one cycle.
- done timing: last-row pop at edge p gives done high during the cycle after edge p+LANES-1, i.e. while out_valid[LANES-1] shows the last element.
- LANES=1 case: FLUSH is skipped; a last pop goes straight to IDLE with done asserted on that edge.
- in_ready is independent of FSM state.
- Illegal state: recovers to IDLE.
- Arithmetic: no arithmetic on data, pass-through only. FIFO pointers are log2(DEPTH)+1 bits; full/empty come from MSB compare, and wrap-around is exercised.

Decomposition:
- systolic_pkg holds LANES, DATA_W defaults and one-hot state constants (ST_IDLE=3'b001, ST_STREAM=3'b010, ST_FLUSH=3'b100).
- One sub-module, operand_fifo: sync FIFO, width LANES*DATA_W+1, depth DEPTH, async active-low reset, exposing push, pop, full, empty, rd_data (show-ahead).
- Skew chains are generated inline.

Test Plan:
- Single vector {4,3,2,1} (lane0=1) with last=1, FIFO empty at reset release → out_valid=0001,0010,0100,1000 on consecutive cycles carrying 1,2,3,4; done high in the same cycle as 1000; busy low the following cycle.
- Frame of 3 back-to-back vectors, last on third → out_valid sequence 0001,0011,0111,1110,1100,1000, one done, no bubbles.
- Upstream gap: vector A, one idle cycle, then B(last) → lane-0 valid pattern 1,0,1, skewed identically on each lane with zeros in the gap; done after B reaches lane 3.
- Backpressure: 6 pushes attempted while in_ready is held off by a full FIFO (DEPTH=4) → in_ready=0 after 4 un-popped writes, no data loss or duplication, pointer wrap verified by 10-vector frame order.
- Two frames queued back-to-back → second frame's first lane-0 valid appears only after the first frame's done; no overlap.
- rst_n asserted mid-STREAM with 2 vectors in FIFO → out_valid=0, busy=0 immediately (async); after release in_ready=1, no done, a fresh frame behaves as in the first scenario.
